host_channel_arbiter: RTL and testbench

//  Shares the single host byte channel (FTDI side) between NUM_CH command cores (lowspeed core,

---
 rtl/host_channel_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_host_channel_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_channel_arbiter.sv
// -----------------------------------------------------------------------------
// host_channel_arbiter
//
// Shares the single host byte channel between NUM_CH command cores, all of
// which speak an 8-bit valid/ready byte stream.
//
//  Host -> core : length-framed packets. A header byte {ch[1:0], len[5:0]} is
//                 followed by len payload bytes, passed combinationally to the
//                 addressed core. Packets for a non-existent channel are
//                 drained and flagged.
//  Core -> host : round-robin arbitration between cores. A granted core's
//                 burst (up to BURST_MAX bytes) is buffered, then sent to the
//                 host prefixed by a header byte {ch[1:0], 3'b000, count[2:0]}.
//
// The two directions are independent and run concurrently.
//
// Ports
//  clock, reset          system clock, asynchronous active-high reset
//  host_rd_*             byte stream from the host (valid/ready)
//  host_wr_*             byte stream to the host (valid/ready)
//  ch_rd_data_o          payload lanes, lane n at [8n+7:8n], all carry host data
//  ch_rd_valid_o/ready_i per-core payload handshake
//  ch_wr_data_i          response lanes from the cores, lane n at [8n+7:8n]
//  ch_wr_valid_i/ready_o per-core response handshake
//  error_bad_channel_o   sticky flag: a header addressed a channel >= NUM_CH
// -----------------------------------------------------------------------------
module host_channel_arbiter #(
  parameter int NUM_CH    = 4,  // 2..4
  parameter int BURST_MAX = 4   // 1..7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            host_rd_data_i,
  input  logic                  host_rd_valid_i,
  output logic                  host_rd_ready_o,
  output logic [7:0]            host_wr_data_o,
  output logic                  host_wr_valid_o,
  input  logic                  host_wr_ready_i,
  output logic [8*NUM_CH-1:0]   ch_rd_data_o,
  output logic [NUM_CH-1:0]     ch_rd_valid_o,
  input  logic [NUM_CH-1:0]     ch_rd_ready_i,
  input  logic [8*NUM_CH-1:0]   ch_wr_data_i,
  input  logic [NUM_CH-1:0]     ch_wr_valid_i,
  output logic [NUM_CH-1:0]     ch_wr_ready_o,
  output logic                  error_bad_channel_o
);

  typedef enum logic [1:0] {US_HEADER, US_PAYLOAD, US_DRAIN} us_state_t;
  typedef enum logic [1:0] {DS_IDLE, DS_COLLECT, DS_HEADER, DS_SEND} ds_state_t;

  localparam logic [2:0] NCH     = 3'(NUM_CH);
  localparam logic [2:0] BMAX    = 3'(BURST_MAX);
  localparam logic [1:0] RR_INIT = 2'(NUM_CH - 1);

  // ---------------------------------------------------------------------------
  // Upstream: host -> core packet router
  // ---------------------------------------------------------------------------
  us_state_t   us_state, us_next;
  logic [1:0]  us_ch;
  logic [5:0]  us_cnt;
  logic        bad_channel;

  logic        host_rd_fire;
  logic [1:0]  hdr_ch;
  logic [5:0]  hdr_len;
  logic        hdr_bad;

  assign host_rd_fire = host_rd_valid_i & host_rd_ready_o;
  assign hdr_ch       = host_rd_data_i[7:6];
  assign hdr_len      = host_rd_data_i[5:0];
  assign hdr_bad      = ({1'b0, hdr_ch} >= NCH);

  // Every lane sees the host byte; only the valid bit selects the consumer.
  assign ch_rd_data_o        = {NUM_CH{host_rd_data_i}};
  assign error_bad_channel_o = bad_channel;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) us_state <= US_HEADER;
    else       us_state <= us_next;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    us_next = us_state;
    case (us_state)
      US_HEADER: begin
        if (host_rd_fire && hdr_len != 6'd0) us_next = hdr_bad ? US_DRAIN : US_PAYLOAD;
      end
      US_PAYLOAD, US_DRAIN: begin
        if (host_rd_fire && us_cnt == 6'd1) us_next = US_HEADER;
      end
      default: us_next = US_HEADER;
    endcase
  end

  always_comb begin
    host_rd_ready_o = 1'b0;
    ch_rd_valid_o   = '0;
    case (us_state)
      // Held low while reset is asserted so all outputs read 0 in reset.
      US_HEADER, US_DRAIN: host_rd_ready_o = ~reset;
      US_PAYLOAD: begin
        host_rd_ready_o      = ch_rd_ready_i[us_ch];
        ch_rd_valid_o[us_ch] = host_rd_valid_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      us_ch       <= '0;
      us_cnt      <= '0;
      bad_channel <= 1'b0;
    end else if (host_rd_fire) begin
      if (us_state == US_HEADER) begin
        us_ch  <= hdr_ch;
        us_cnt <= hdr_len;
        if (hdr_bad) bad_channel <= 1'b1;
      end else begin
        us_cnt <= us_cnt - 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Downstream: core -> host burst arbiter
  // ---------------------------------------------------------------------------
  ds_state_t   ds_state, ds_next;
  logic [1:0]  rr;
  logic [1:0]  grant;
  logic [2:0]  ds_cnt;
  logic [2:0]  ds_idx;
  logic [7:0]  burst_buf [8];  // indexed directly by the 3-bit count

  logic        any_valid;
  logic [1:0]  pick;
  logic [1:0]  lane;
  logic        found;
  logic        g_valid;
  logic [7:0]  g_data;
  logic        collect_fire;

  // Round-robin search: first requesting lane after the last grant.
  always_comb begin
    pick  = rr;
    lane  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      lane = 2'((int'(rr) + i) % NUM_CH);
      if (!found && ch_wr_valid_i[lane]) begin
        found = 1'b1;
        pick  = lane;
      end
    end
  end

  assign any_valid    = |ch_wr_valid_i;
  assign g_valid      = ch_wr_valid_i[grant];
  assign g_data       = ch_wr_data_i[{grant, 3'b000} +: 8];
  assign collect_fire = (ds_state == DS_COLLECT) && g_valid && (ds_cnt < BMAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ds_state <= DS_IDLE;
    else       ds_state <= ds_next;
  end

  always_comb begin
    ds_next = ds_state;
    case (ds_state)
      DS_IDLE:    if (any_valid) ds_next = DS_COLLECT;
      // Burst ends when full, or when the core pauses after at least one byte.
      DS_COLLECT: if (ds_cnt == BMAX || (!g_valid && ds_cnt != 3'd0)) ds_next = DS_HEADER;
      DS_HEADER:  if (host_wr_ready_i) ds_next = DS_SEND;
      DS_SEND:    if (host_wr_ready_i && ds_idx == 3'(ds_cnt - 3'd1)) ds_next = DS_IDLE;
      default:    ds_next = DS_IDLE;
    endcase
  end

  always_comb begin
    host_wr_valid_o = 1'b0;
    host_wr_data_o  = '0;
    ch_wr_ready_o   = '0;
    case (ds_state)
      DS_COLLECT: ch_wr_ready_o[grant] = (ds_cnt < BMAX);
      DS_HEADER: begin
        host_wr_valid_o = 1'b1;
        host_wr_data_o  = {grant, 3'b000, ds_cnt};
      end
      DS_SEND: begin
        host_wr_valid_o = 1'b1;
        host_wr_data_o  = burst_buf[ds_idx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr     <= RR_INIT;
      grant  <= '0;
      ds_cnt <= '0;
      ds_idx <= '0;
    end else begin
      case (ds_state)
        DS_IDLE: begin
          if (any_valid) begin
            grant  <= pick;
            rr     <= pick;
            ds_cnt <= '0;
          end
        end
        DS_COLLECT: if (collect_fire) ds_cnt <= ds_cnt + 3'd1;
        DS_HEADER:  if (host_wr_ready_i) ds_idx <= '0;
        DS_SEND:    if (host_wr_ready_i) ds_idx <= ds_idx + 3'd1;
        default: ;
      endcase
    end
  end

  // NOTE: the burst buffer has no reset; a byte is only read after it has been
  // written in the current burst, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (collect_fire) burst_buf[ds_cnt] <= g_data;
  end

endmodule

// File: tb/tb_host_channel_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for host_channel_arbiter. Expected host-bound bytes and
// expected core-bound payload bytes are queued as stimulus is issued, and
// popped/compared by monitors whenever the DUT completes a handshake.
// A second instance with NUM_CH=3 exercises the bad-channel drain path.
// -----------------------------------------------------------------------------
module tb_host_channel_arbiter;
  localparam int NCH = 4;

  logic                clock = 1'b0;
  logic                reset;

  logic [7:0]          host_rd_data_i;
  logic                host_rd_valid_i;
  logic                host_rd_ready_o;
  logic [7:0]          host_wr_data_o;
  logic                host_wr_valid_o;
  logic                host_wr_ready_i;
  logic [8*NCH-1:0]    ch_rd_data_o;
  logic [NCH-1:0]      ch_rd_valid_o;
  logic [NCH-1:0]      ch_rd_ready_i;
  logic [8*NCH-1:0]    ch_wr_data_i;
  logic [NCH-1:0]      ch_wr_valid_i;
  logic [NCH-1:0]      ch_wr_ready_o;
  logic                error_bad_channel_o;

  logic [7:0]          d3_rd_data;
  logic                d3_rd_valid;
  logic                d3_rd_ready;
  logic [7:0]          d3_wr_data;
  logic                d3_wr_valid;
  logic                d3_wr_ready;
  logic [23:0]         d3_ch_rd_data;
  logic [2:0]          d3_ch_rd_valid;
  logic [2:0]          d3_ch_rd_ready;
  logic [23:0]         d3_ch_wr_data;
  logic [2:0]          d3_ch_wr_valid;
  logic [2:0]          d3_ch_wr_ready;
  logic                d3_err;
  logic                d3_quiet;

  host_channel_arbiter #(.NUM_CH(NCH), .BURST_MAX(4)) u_dut (
    .clock               (clock),
    .reset               (reset),
    .host_rd_data_i      (host_rd_data_i),
    .host_rd_valid_i     (host_rd_valid_i),
    .host_rd_ready_o     (host_rd_ready_o),
    .host_wr_data_o      (host_wr_data_o),
    .host_wr_valid_o     (host_wr_valid_o),
    .host_wr_ready_i     (host_wr_ready_i),
    .ch_rd_data_o        (ch_rd_data_o),
    .ch_rd_valid_o       (ch_rd_valid_o),
    .ch_rd_ready_i       (ch_rd_ready_i),
    .ch_wr_data_i        (ch_wr_data_i),
    .ch_wr_valid_i       (ch_wr_valid_i),
    .ch_wr_ready_o       (ch_wr_ready_o),
    .error_bad_channel_o (error_bad_channel_o)
  );

  host_channel_arbiter #(.NUM_CH(3), .BURST_MAX(4)) u_dut3 (
    .clock               (clock),
    .reset               (reset),
    .host_rd_data_i      (d3_rd_data),
    .host_rd_valid_i     (d3_rd_valid),
    .host_rd_ready_o     (d3_rd_ready),
    .host_wr_data_o      (d3_wr_data),
    .host_wr_valid_o     (d3_wr_valid),
    .host_wr_ready_i     (d3_wr_ready),
    .ch_rd_data_o        (d3_ch_rd_data),
    .ch_rd_valid_o       (d3_ch_rd_valid),
    .ch_rd_ready_i       (d3_ch_rd_ready),
    .ch_wr_data_i        (d3_ch_wr_data),
    .ch_wr_valid_i       (d3_ch_wr_valid),
    .ch_wr_ready_o       (d3_ch_wr_ready),
    .error_bad_channel_o (d3_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [7:0] ds_q[$];  // expected bytes towards the host
  logic [9:0] us_q[$];  // expected {channel, byte} towards the cores

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitors sample on the falling edge; a handshake seen here completes on
  // the following rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (host_wr_valid_o && host_wr_ready_i) begin
        if (ds_q.size() == 0) check("ds_unexpected_byte_q", 32'(ds_q.size()), 1);
        else                  check("ds_byte", host_wr_data_o, ds_q.pop_front());
      end
      check("us_valid_onehot0", $onehot0(ch_rd_valid_o), 1);
      for (int c = 0; c < NCH; c++) begin
        if (ch_rd_valid_o[c] && ch_rd_ready_i[c]) begin
          logic [9:0] obs;
          obs = {2'(c), ch_rd_data_o[8*c +: 8]};
          if (us_q.size() == 0) check("us_unexpected_byte_q", 32'(us_q.size()), 1);
          else                  check("us_byte", obs, us_q.pop_front());
        end
      end
      if (d3_quiet) check("d3_no_lane_valid", d3_ch_rd_valid, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic host_send(input logic [7:0] b);
    host_rd_data_i  = b;
    host_rd_valid_i = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clock);
      if (host_rd_ready_o) break;
      if (t > 200) begin check("host_rd_timeout", host_rd_ready_o, 1); break; end
    end
    @(posedge clock); #1;
    host_rd_valid_i = 1'b0;
  endtask

  task automatic d3_send(input logic [7:0] b);
    d3_rd_data  = b;
    d3_rd_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clock);
      if (d3_rd_ready) break;
      if (t > 200) begin check("d3_rd_timeout", d3_rd_ready, 1); break; end
    end
    @(posedge clock); #1;
    d3_rd_valid = 1'b0;
  endtask

  // Core ch streams n bytes base, base+1, ... keeping valid high throughout.
  task automatic core_send(input int ch, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      ch_wr_data_i[8*ch +: 8] = base + 8'(k);
      ch_wr_valid_i[ch]       = 1'b1;
      for (int t = 0; ; t++) begin
        @(negedge clock);
        if (ch_wr_ready_o[ch]) break;
        if (t > 300) begin check("core_ready_timeout", ch_wr_ready_o[ch], 1); break; end
      end
      @(posedge clock); #1;
    end
    ch_wr_valid_i[ch] = 1'b0;
  endtask

  task automatic push_ds(input logic [7:0] hdr, input logic [7:0] base, input int n);
    ds_q.push_back(hdr);
    for (int k = 0; k < n; k++) ds_q.push_back(base + 8'(k));
  endtask

  task automatic wait_ds_drain();
    for (int t = 0; ; t++) begin
      @(negedge clock);
      if (ds_q.size() == 0 && !host_wr_valid_o) break;
      if (t > 500) begin check("ds_drain_timeout", 32'(ds_q.size()), 0); break; end
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_host_valid(input string tag);
    for (int t = 0; ; t++) begin
      @(negedge clock);
      if (host_wr_valid_o) break;
      if (t > 200) begin check(tag, host_wr_valid_o, 1); break; end
    end
  endtask

  initial begin
    reset           = 1'b1;
    host_rd_data_i  = 8'h5E;
    host_rd_valid_i = 1'b0;
    host_wr_ready_i = 1'b1;
    ch_rd_ready_i   = '1;
    ch_wr_data_i    = '0;
    ch_wr_valid_i   = '0;
    d3_rd_data      = '0;
    d3_rd_valid     = 1'b0;
    d3_wr_ready     = 1'b0;
    d3_ch_rd_ready  = '1;
    d3_ch_wr_data   = '0;
    d3_ch_wr_valid  = '0;
    d3_quiet        = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clock);
    check("rst_host_rd_ready", host_rd_ready_o, 0);
    check("rst_host_wr_valid", host_wr_valid_o, 0);
    check("rst_host_wr_data", host_wr_data_o, 0);
    check("rst_ch_rd_valid", ch_rd_valid_o, 0);
    check("rst_ch_wr_ready", ch_wr_ready_o, 0);
    check("rst_error", error_bad_channel_o, 0);
    check("rst_ch_rd_data_copy", ch_rd_data_o, {4{8'h5E}});
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("idle_host_rd_ready", host_rd_ready_o, 1);
    @(posedge clock); #1;

    // ---- 1: upstream routing, backpressure, zero-length header ----
    us_q.push_back({2'd1, 8'h11});
    us_q.push_back({2'd1, 8'h22});
    us_q.push_back({2'd1, 8'h33});
    host_send(8'h43);
    host_send(8'h11);
    ch_rd_ready_i[1] = 1'b0;
    host_rd_data_i   = 8'h22;
    host_rd_valid_i  = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("us_bp_host_ready", host_rd_ready_o, 0);
      check("us_bp_lane_valid", ch_rd_valid_o, 4'b0010);
    end
    @(posedge clock); #1;
    ch_rd_ready_i[1] = 1'b1;
    host_send(8'h22);
    host_send(8'h33);
    for (int k = 0; k < 4; k++) us_q.push_back({2'd1, 8'hA0 + 8'(k)});
    host_send(8'h44);
    for (int k = 0; k < 4; k++) host_send(8'hA0 + 8'(k));
    host_send(8'h00);  // empty packet: stays in header state
    us_q.push_back({2'd2, 8'h55});
    us_q.push_back({2'd2, 8'h66});
    host_send(8'h82);
    host_send(8'h55);
    host_send(8'h66);
    @(negedge clock);
    check("us_all_delivered", 32'(us_q.size()), 0);
    check("us_back_to_header", host_rd_ready_o, 1);
    check("us_no_error", error_bad_channel_o, 0);
    @(posedge clock); #1;

    // ---- 2: NUM_CH=3, bad channel drains and sets sticky error ----
    d3_quiet = 1'b1;
    d3_send(8'hC2);
    d3_send(8'hAA);
    d3_send(8'hBB);
    d3_send(8'h00);
    @(negedge clock);
    check("d3_error_set", d3_err, 1);
    check("d3_header_ready", d3_rd_ready, 1);
    @(posedge clock); #1;
    d3_quiet = 1'b0;
    d3_send(8'h41);
    d3_rd_data  = 8'h99;
    d3_rd_valid = 1'b1;
    @(negedge clock);
    check("d3_routes_after_drain", d3_ch_rd_valid, 3'b010);
    check("d3_error_sticky", d3_err, 1);
    @(posedge clock); #1;
    d3_rd_valid = 1'b0;

    // ---- 4: round robin right after reset (rr = NUM_CH-1) ----
    push_ds(8'h01, 8'h10, 1);
    push_ds(8'hC1, 8'h30, 1);
    fork
      core_send(0, 1, 8'h10);
      core_send(3, 1, 8'h30);
    join
    wait_ds_drain();
    push_ds(8'h01, 8'h11, 1);
    push_ds(8'hC1, 8'h31, 1);
    fork
      core_send(0, 1, 8'h11);
      core_send(3, 1, 8'h31);
    join
    wait_ds_drain();

    // ---- 3: three-byte burst from ch2 ----
    push_ds(8'h83, 8'h5A, 3);
    core_send(2, 3, 8'h5A);
    wait_ds_drain();

    // ---- 5: six bytes from ch1 split into 4 + 2 ----
    push_ds(8'h44, 8'h60, 4);
    push_ds(8'h42, 8'h64, 2);
    core_send(1, 6, 8'h60);
    wait_ds_drain();

    // ---- 6a: host stalls mid-send, data/valid held ----
    host_wr_ready_i = 1'b0;
    push_ds(8'h02, 8'hA1, 2);
    core_send(0, 2, 8'hA1);
    wait_host_valid("t6_header_timeout");
    check("t6_header_byte", host_wr_data_o, 8'h02);
    @(posedge clock); #1;
    host_wr_ready_i = 1'b1;
    @(posedge clock); #1;
    host_wr_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("t6_hold_valid", host_wr_valid_o, 1);
      check("t6_hold_data", host_wr_data_o, 8'hA1);
    end
    @(posedge clock); #1;
    host_wr_ready_i = 1'b1;
    wait_ds_drain();

    // ---- 6b: reset mid-send drops the rest of the burst ----
    host_wr_ready_i = 1'b0;
    core_send(0, 3, 8'hB1);
    wait_host_valid("t6_rst_header_timeout");
    push_ds(8'h03, 8'hB1, 1);
    @(posedge clock); #1;
    host_wr_ready_i = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    host_wr_ready_i = 1'b0;
    @(negedge clock);
    check("t6_mid_valid", host_wr_valid_o, 1);
    check("t6_mid_data", host_wr_data_o, 8'hB2);
    reset = 1'b1;
    #1;
    check("t6_reset_valid", host_wr_valid_o, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    check("t6_sent_before_reset", 32'(ds_q.size()), 0);
    host_wr_ready_i = 1'b1;
    push_ds(8'h41, 8'hC7, 1);
    core_send(1, 1, 8'hC7);
    wait_ds_drain();

    check("end_ds_queue_empty", 32'(ds_q.size()), 0);
    check("end_us_queue_empty", 32'(us_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
